// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle add/sub/logic/shift, iterative shift-and-add multiply,
// registered result and Z/C/V/N flags held on a valid/ready output channel until consumed.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_neg;

    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [SHW-1:0]   r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;

    logic [PW-1:0]    w_acc_nx;
    logic             w_mul_last;
    logic             w_mul_go;
    logic             w_load;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
    logic             w_fin_v;

    // Single-cycle datapath; extra top/bottom bit captures carry, borrow and shifted-out bit
    always_comb begin
        w_amt     = b[SHW-1:0];
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_shl     = {1'b0, a} << w_amt;
        w_shr     = {a, 1'b0} >> w_amt;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                w_alu_c   = w_shr[0];
            end
            default: ;
        endcase
    end

    // Last multiply iteration feeds its sum straight into the result register
    assign w_acc_nx   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

    always_comb begin
        w_state_nx = r_state;
        w_mul_go   = 1'b0;
        w_load     = 1'b0;
        w_fin_res  = w_alu_res;
        w_fin_c    = w_alu_c;
        w_fin_v    = w_alu_v;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        w_mul_go   = 1'b1;
                        w_state_nx = S_BUSY;
                    end else begin
                        w_load     = 1'b1;
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (w_mul_last) begin
                    w_load     = 1'b1;
                    w_fin_res  = w_acc_nx[WIDTH-1:0];
                    w_fin_c    = |w_acc_nx[PW-1:WIDTH];
                    w_fin_v    = 1'b0;
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx == S_IDLE);
            r_out_valid <= (w_state_nx == S_DONE);
        end
    end

    // Result and flags change only when entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
            r_carry  <= w_fin_c;
            r_ovf    <= w_fin_v;
            r_neg    <= w_fin_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_go) begin
            r_mcand  <= PW'(a);
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign negative  = r_neg;

endmodule
